// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'h9;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// Double-dabble correction cell: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter feeding the seven-segment driver, one bit per clock.
// Define BIN2BCD_SAT_EN to show all nines instead of the truncated value on overflow.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                          out_valid,
  output logic                          overflow
);

  localparam int AW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] OVF_THRESH = WIDTH'(pow10(DIGITS));
`ifdef BIN2BCD_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_shreg;
  logic [AW-1:0]    r_acc;
  logic [AW-1:0]    w_accAdj;
  logic [AW-1:0]    w_result;
  logic [CW-1:0]    r_cnt;
  logic             r_ovfPending;
  logic [AW-1:0]    r_outBcd;
  logic             r_outValid;
  logic             r_overflow;
  logic             w_accept;
  logic             w_shiftEn;
  logic             w_finish;

  for (genvar g = 0; g < DIGITS; g++) begin : gDigit
    bcd_digit_adj uAdj (
      .i_digit(r_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit(w_accAdj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Held off for the out_valid cycle so a new request cannot overlap the pulse.
  assign in_ready = (r_state == IDLE) && !r_outValid;

  assign w_result = (SAT_EN && r_ovfPending) ? {DIGITS{BCD_NINE}} : r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_shiftEn   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && in_ready) begin
          w_accept    = 1'b1;
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        w_shiftEn = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_finish    = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The carry out of the top digit is dropped, leaving value mod 10^DIGITS.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg      <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ovfPending <= 1'b0;
      r_outBcd     <= '0;
      r_outValid   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      if (w_accept) begin
        r_shreg      <= in_data;
        r_acc        <= '0;
        r_cnt        <= CW'(WIDTH);
        r_ovfPending <= (in_data >= OVF_THRESH);
      end else if (w_shiftEn) begin
        r_acc   <= {w_accAdj[AW-2:0], r_shreg[WIDTH-1]};
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
        r_cnt   <= r_cnt - CW'(1);
      end
      if (w_finish) begin
        r_outBcd   <= w_result;
        r_overflow <= r_ovfPending;
        r_outValid <= 1'b1;
      end
    end
  end

  assign out_bcd   = r_outBcd;
  assign out_valid = r_outValid;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and randomized bench for bin2bcd_seq against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] out_bcd;
  logic        out_valid;
  logic        overflow;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] prevBcd;

  always #5 clk = ~clk;

  bin2bcd_seq #(
    .WIDTH (16),
    .DIGITS(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_bcd  (out_bcd),
    .out_valid(out_valid),
    .overflow (overflow)
  );

  // Decimal digits by division; values past 9999 either wrap or saturate.
  function automatic logic [15:0] refBcd(input int unsigned v);
    int unsigned r;
`ifdef BIN2BCD_SAT_EN
    if (v >= 10000) return 16'h9999;
`endif
    r = v % 10000;
    return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full conversion: handshake, bounded wait for the pulse, then result checks.
  task automatic applyStimulus(input logic [15:0] value, input bit keepValid,
                               input logic [15:0] nextData, input bit scramble);
    int          n;
    logic [15:0] seen;
    bit          moved;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready) checkOutput("ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = value;
    tick();
    checkOutput("busy_ready", 32'(in_ready), 32'd0);
    if (keepValid) in_data = nextData;
    else if (!scramble) in_valid = 1'b0;
    seen  = prevBcd;
    moved = 1'b0;
    n     = 0;
    while (n < 40) begin
      if (scramble) in_data = 16'($urandom);
      tick();
      n++;
      if (out_valid) break;
      if (!moved && out_bcd !== prevBcd) begin
        moved = 1'b1;
        seen  = out_bcd;
      end
    end
    if (!keepValid) in_valid = 1'b0;
    if (!out_valid) checkOutput("valid_timeout", 32'(out_valid), 32'd1);
    checkOutput("latency", 32'(n), 32'd17);
    checkOutput("hold_during_busy", 32'(seen), 32'(prevBcd));
    checkOutput("bcd", 32'(out_bcd), 32'(refBcd(32'(value))));
    checkOutput("overflow", 32'(overflow), 32'(value >= 16'd10000));
    prevBcd = refBcd(32'(value));
    tick();
    checkOutput("valid_one_cycle", 32'(out_valid), 32'd0);
    checkOutput("ready_back", 32'(in_ready), 32'd1);
    checkOutput("bcd_held", 32'(out_bcd), 32'(prevBcd));
  endtask

  initial begin
    int pulses;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_bcd", 32'(out_bcd), 32'd0);
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    prevBcd = 16'h0000;

    applyStimulus(16'd1234, 1'b0, 16'd0, 1'b0);
    applyStimulus(16'd0, 1'b1, 16'd9999, 1'b0);
    applyStimulus(16'd9999, 1'b0, 16'd0, 1'b0);
    applyStimulus(16'd10000, 1'b0, 16'd0, 1'b0);
    applyStimulus(16'd65535, 1'b0, 16'd0, 1'b0);
    applyStimulus(16'd42, 1'b0, 16'd0, 1'b0);
    applyStimulus(16'd65535, 1'b0, 16'd0, 1'b0);

    // Abort 4321 in its 8th shift cycle.
    in_valid = 1'b1;
    in_data  = 16'd4321;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_bcd", 32'(out_bcd), 32'd0);
    checkOutput("abort_overflow", 32'(overflow), 32'd0);
    checkOutput("abort_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_valid", 32'(out_valid), 32'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    checkOutput("abort_no_pulse", 32'(pulses), 32'd0);
    prevBcd = 16'h0000;

    applyStimulus(16'd1234, 1'b0, 16'd0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      applyStimulus(16'($urandom_range(0, 65535)), 1'b0, 16'd0, bit'(i % 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
